// File: rtl/sort_sequencer.sv
`default_nettype none
// sort_sequencer: 7-value odd-even transposition sorter, one compare-exchange phase per cycle.
// Optional macro SORT_EARLY_EXIT_EN ends SORT after an even/odd phase pair with no swaps.
module sort_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PHASES = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refresh,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [DATA_WIDTH-1:0] in4,
  input  logic [DATA_WIDTH-1:0] in5,
  input  logic [DATA_WIDTH-1:0] in6,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic [DATA_WIDTH-1:0] median,
  output logic                  busy,
  output logic [2:0]            phase_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] r   [7];
  logic [DATA_WIDTH-1:0] nxt [7];
  logic [DATA_WIDTH-1:0] din [7];
  logic                  finish;

`ifdef SORT_EARLY_EXIT_EN
  logic any_swap;
  logic prev_quiet;
`endif

  assign din[0] = in0;
  assign din[1] = in1;
  assign din[2] = in2;
  assign din[3] = in3;
  assign din[4] = in4;
  assign din[5] = in5;
  assign din[6] = in6;

  // Pairs of one parity are disjoint, so each element is written at most once per phase.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      nxt[i] = r[i];
    end
`ifdef SORT_EARLY_EXIT_EN
    any_swap = 1'b0;
`endif
    for (int i = 0; i < 6; i++) begin
      if ((i & 1) == int'(phase_cnt[0])) begin
        if (r[i] > r[i+1]) begin
          nxt[i]   = r[i+1];
          nxt[i+1] = r[i];
`ifdef SORT_EARLY_EXIT_EN
          any_swap = 1'b1;
`endif
        end
      end
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  assign finish = (phase_cnt == LAST_PHASE) || (!any_swap && prev_quiet);
`else
  assign finish = (phase_cnt == LAST_PHASE);
`endif

  always_ff @(posedge clk) begin
    if (!rst || refresh) begin
      state     <= IDLE;
      for (int i = 0; i < 7; i++) begin
        r[i] <= '0;
      end
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      phase_cnt <= 3'd0;
`ifdef SORT_EARLY_EXIT_EN
      prev_quiet <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 7; i++) begin
              r[i] <= din[i];
            end
            state     <= SORT;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            phase_cnt <= 3'd0;
`ifdef SORT_EARLY_EXIT_EN
            prev_quiet <= 1'b0;
`endif
          end
        end
        SORT: begin
          for (int i = 0; i < 7; i++) begin
            r[i] <= nxt[i];
          end
`ifdef SORT_EARLY_EXIT_EN
          prev_quiet <= !any_swap;
`endif
          if (finish) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            phase_cnt <= 3'd0;
          end else begin
            phase_cnt <= phase_cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          phase_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign out0   = r[0];
  assign out1   = r[1];
  assign out2   = r[2];
  assign out3   = r[3];
  assign out4   = r[4];
  assign out5   = r[5];
  assign out6   = r[6];
  assign median = r[3];

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// tb_sort_sequencer: scoreboard bench with a behavioural sort/latency model.
module tb_sort_sequencer;
  localparam int DW = 8;
  localparam int NP = 7;

  typedef logic [6:0][DW-1:0] win_t;
  typedef struct {
    win_t exp;
    int   t_acc;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst, refresh, in_valid, out_ready;
  logic in_ready, out_valid, busy;
  logic [2:0] phase_cnt;
  logic [DW-1:0] in0, in1, in2, in3, in4, in5, in6;
  logic [DW-1:0] out0, out1, out2, out3, out4, out5, out6, median;
  win_t w_in, outs;

  assign {in6, in5, in4, in3, in2, in1, in0} = w_in;
  assign outs = {out6, out5, out4, out3, out2, out1, out0};

  sort_sequencer #(.DATA_WIDTH(DW), .NUM_PHASES(NP)) dut (
    .clk(clk), .rst(rst), .refresh(refresh),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5), .out6(out6),
    .median(median), .busy(busy), .phase_cnt(phase_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic win_t sort7(input win_t v);
    win_t a = v;
    logic [DW-1:0] t;
    for (int i = 0; i < 7; i++)
      for (int j = i + 1; j < 7; j++)
        if (a[j] < a[i]) begin
          t = a[i]; a[i] = a[j]; a[j] = t;
        end
    return a;
  endfunction

  // Edges from accept to the first edge that samples out_valid=1.
  function automatic int model_lat(input win_t v);
`ifdef SORT_EARLY_EXIT_EN
    int a[7];
    bit quiet_prev = 0;
    bit swapped;
    int t;
    for (int i = 0; i < 7; i++) a[i] = int'(v[i]);
    for (int p = 0; p < NP; p++) begin
      swapped = 0;
      for (int i = p % 2; i + 1 < 7; i += 2)
        if (a[i] > a[i+1]) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t; swapped = 1;
        end
      if (!swapped && quiet_prev) return p + 2;
      quiet_prev = !swapped;
    end
    return NP + 1;
`else
    return NP + 1 + 0 * int'(v[0]);
`endif
  endfunction

  // Monitor: decoupled from stimulus, sampled 1 time unit after the falling edge.
  initial begin : monitor
    bit   held = 0;
    win_t snap;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (!held) begin
          held = 1;
          snap = outs;
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            chk("latency", 64'(cyc + 1 - sb[0].t_acc), 64'(sb[0].lat));
          end
        end else begin
          chk("hold_stable", 64'(outs), 64'(snap));
        end
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready === 1'b1 && sb.size() > 0) begin
          chk("sorted_data", 64'(outs), 64'(sb[0].exp));
          chk("median", 64'(median), 64'(sb[0].exp[3]));
          void'(sb.pop_front());
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic send(input win_t v);
    int g = 0;
    while (in_ready !== 1'b1 && g < 200) begin
      @(negedge clk); g++;
    end
    if (g >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    in_valid = 1'b1;
    w_in     = v;
    sb.push_back('{sort7(v), cyc + 1, model_lat(v)});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int g = 0;
    while (sb.size() > 0 && g < 500) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); g++;
    end
    if (g >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int g = 0;
    while (out_valid !== 1'b1 && g < 100) begin
      @(negedge clk); g++;
    end
    if (g >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL wait_valid_timeout actual=0 required=1");
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_outs"}, 64'(outs), 64'd0);
    chk({tag, "_median"}, 64'(median), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_phase_cnt"}, 64'(phase_cnt), 64'd0);
  endtask

  function automatic win_t mk(input int a0, a1, a2, a3, a4, a5, a6);
    win_t v;
    v[0] = DW'(a0); v[1] = DW'(a1); v[2] = DW'(a2); v[3] = DW'(a3);
    v[4] = DW'(a4); v[5] = DW'(a5); v[6] = DW'(a6);
    return v;
  endfunction

  initial begin : stim
    int g;
    win_t v;
    rst = 1'b0; refresh = 1'b0; in_valid = 1'b0; out_ready = 1'b1; w_in = '0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed windows from the plan.
    send(mk(7, 6, 5, 4, 3, 2, 1)); drain(0);
    send(mk(1, 2, 3, 4, 5, 6, 7)); drain(0);
    send(mk(200, 0, 200, 5, 0, 255, 5)); drain(0);

    // Backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    send(mk(9, 250, 3, 128, 127, 0, 9));
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      w_in     = win_t'({$urandom, $urandom});
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_after_xfer", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after_xfer", 64'(out_valid), 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Abort with refresh at phase 3.
    send(mk(70, 60, 50, 40, 30, 20, 10));
    g = 0;
    while (phase_cnt !== 3'd3 && g < 50) begin
      @(negedge clk); g++;
    end
    chk("abort_reached_phase3", 64'(phase_cnt), 64'd3);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    chk_cleared("abort");
    void'(sb.pop_back());
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_no_out_valid", 64'(out_valid), 64'd0);
    end
    send(mk(9, 8, 7, 6, 5, 4, 3)); drain(0);

    // Reset while holding in DONE.
    out_ready = 1'b0;
    send(mk(3, 1, 4, 1, 5, 9, 2));
    wait_valid();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_cleared("rst_done");
    void'(sb.pop_front());
    out_ready = 1'b1;
    @(negedge clk);

    // refresh together with in_valid in IDLE: no accept.
    in_valid = 1'b1; refresh = 1'b1; w_in = mk(5, 4, 3, 2, 1, 0, 6);
    @(negedge clk);
    in_valid = 1'b0; refresh = 1'b0;
    chk("refresh_vs_valid_busy", 64'(busy), 64'd0);
    chk("refresh_vs_valid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("refresh_vs_valid_still_idle", 64'(busy), 64'd0);

    // Randomized windows, random backpressure, mix of narrow and full ranges.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 7; i++)
        v[i] = (n % 2 == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      if (n % 7 == 3) v = sort7(v);
      send(v);
      drain(1);
    end

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_cmp++; n_err++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
